// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/state types and the legal-opcode mask for alu_arbiter.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu_state_e;

  // Bit k set means opcode k is implemented; 100, 110 and 111 are illegal.
  localparam logic [7:0] ALU_LEGAL_MASK = 8'b0010_1111;

  function automatic logic alu_is_legal(input logic [2:0] op);
    return ALU_LEGAL_MASK[op];
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: 2-way grant picker. Round-robin by default; with
// ALU_ARBITER_FIXED_PRIO_EN defined, requester 0 always wins a contention
// and no priority state exists.
module alu_rr_pick (
`ifndef ALU_ARBITER_FIXED_PRIO_EN
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_update,
`endif
  input  logic [1:0] i_valid,
  output logic       o_any,
  output logic       o_grant
);

  assign o_any = |i_valid;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  // Requester 1 only wins when it is the sole requester.
  assign o_grant = i_valid[1] & ~i_valid[0];
`else
  // r_ptr names the requester favoured on the next contention.
  logic r_ptr;

  // Contention follows the pointer; a single requester is granted directly.
  assign o_grant = (&i_valid) ? r_ptr : (i_valid[1] & ~i_valid[0]);

  // Pointer moves to the other requester after every transfer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_update) begin
      r_ptr <= ~o_grant;
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one registered ALU, one operation in
// flight at a time (IDLE -> EXEC -> RESP). Build option
// ALU_ARBITER_FIXED_PRIO_EN selects fixed priority to requester 0 instead
// of round-robin.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [1:0]                 i_req_valid,
  output logic [1:0]                 o_req_ready,
  input  logic [2*ALUCTRL_WIDTH-1:0] i_req_ctrl,
  input  logic [2*DATA_WIDTH-1:0]    i_req_op1,
  input  logic [2*DATA_WIDTH-1:0]    i_req_op2,
  output logic                       o_rsp_valid,
  input  logic                       i_rsp_ready,
  output logic                       o_rsp_id,
  output logic [DATA_WIDTH-1:0]      o_rsp_data,
  output logic                       o_rsp_eq,
  output logic                       o_rsp_err
);

  import alu_pkg::*;

  alu_state_e               r_state;
  logic [ALUCTRL_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0]    r_op1;
  logic [DATA_WIDTH-1:0]    r_op2;
  logic                     r_id;
  logic                     r_rsp_valid;
  logic                     r_rsp_id;
  logic [DATA_WIDTH-1:0]    r_rsp_data;
  logic                     r_rsp_eq;
  logic                     r_rsp_err;

  logic                     w_any;
  logic                     w_grant;
  logic                     w_xfer;
  logic [DATA_WIDTH-1:0]    w_result;
  logic                     w_legal;
  logic                     w_eq;

  alu_rr_pick u_pick (
`ifndef ALU_ARBITER_FIXED_PRIO_EN
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_update (w_xfer),
`endif
    .i_valid  (i_req_valid),
    .o_any    (w_any),
    .o_grant  (w_grant)
  );

  // A transfer happens whenever anyone is valid while idle; the grantee is ready.
  assign w_xfer      = w_any && (r_state == ST_IDLE);
  assign o_req_ready = w_xfer ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  assign w_legal = alu_is_legal(3'(r_ctrl));
  assign w_eq    = (r_op1 == r_op2);

  // ALU datapath on the latched operands; illegal opcodes yield zero.
  always_comb begin
    w_result = '0;
    case (r_ctrl)
      ALUCTRL_WIDTH'(OP_ADD): w_result = r_op1 + r_op2;
      ALUCTRL_WIDTH'(OP_SUB): w_result = r_op1 - r_op2;
      ALUCTRL_WIDTH'(OP_AND): w_result = r_op1 & r_op2;
      ALUCTRL_WIDTH'(OP_OR):  w_result = r_op1 | r_op2;
      ALUCTRL_WIDTH'(OP_SLT): w_result = {{(DATA_WIDTH-1){1'b0}}, (r_op1 < r_op2)};
      default:                w_result = '0;
    endcase
  end

  // Control FSM: latch on transfer, register result in EXEC, hold in RESP.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_ctrl      <= '0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_eq    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_EXEC;
            r_id    <= w_grant;
            r_ctrl  <= w_grant ? i_req_ctrl[ALUCTRL_WIDTH +: ALUCTRL_WIDTH]
                               : i_req_ctrl[0 +: ALUCTRL_WIDTH];
            r_op1   <= w_grant ? i_req_op1[DATA_WIDTH +: DATA_WIDTH]
                               : i_req_op1[0 +: DATA_WIDTH];
            r_op2   <= w_grant ? i_req_op2[DATA_WIDTH +: DATA_WIDTH]
                               : i_req_op2[0 +: DATA_WIDTH];
          end
        end
        ST_EXEC: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_id    <= r_id;
          r_rsp_data  <= w_result;
          r_rsp_eq    <= w_eq;
          r_rsp_err   <= ~w_legal;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_eq    = r_rsp_eq;
  assign o_rsp_err   = r_rsp_err;

endmodule
